// File: rtl/usb_fs_nb_out_pe.sv
// Non-buffered USB full-speed OUT/SETUP protocol engine: decodes tokens, streams
// payload bytes to the endpoint buffer and returns the handshake.
module usb_fs_nb_out_pe #(
  parameter int unsigned NumOutEps         = 12,
  parameter int unsigned MaxOutPktSizeByte = 32,
  localparam int unsigned PktW             = $clog2(MaxOutPktSizeByte)
) (
  input  logic                 clk_48mhz_i,
  input  logic                 rst_ni,
  input  logic                 link_reset_i,
  input  logic                 link_active_i,
  input  logic [6:0]           dev_addr_i,

  output logic                 out_xact_starting_o,
  output logic [3:0]           out_xact_start_ep_o,
  output logic [3:0]           out_ep_current_o,
  output logic                 out_ep_setup_o,
  output logic                 out_ep_newpkt_o,
  output logic                 out_ep_data_put_o,
  output logic [PktW-1:0]      out_ep_put_addr_o,
  output logic [7:0]           out_ep_data_o,
  output logic                 out_ep_acked_o,
  output logic                 out_ep_rollback_o,
  input  logic [NumOutEps-1:0] out_ep_enabled_i,
  input  logic [NumOutEps-1:0] out_ep_setup_i,
  input  logic [NumOutEps-1:0] out_ep_full_i,
  input  logic [NumOutEps-1:0] out_ep_stall_i,
  input  logic [NumOutEps-1:0] out_ep_iso_i,
  output logic [NumOutEps-1:0] out_data_toggle_o,
  input  logic                 out_datatog_we_i,
  input  logic [NumOutEps-1:0] out_datatog_status_i,
  input  logic [NumOutEps-1:0] out_datatog_mask_i,

  input  logic                 rx_pkt_start_i,
  input  logic                 rx_pkt_end_i,
  input  logic                 rx_pkt_valid_i,
  input  logic [3:0]           rx_pid_i,
  input  logic [6:0]           rx_addr_i,
  input  logic [3:0]           rx_endp_i,
  input  logic                 rx_data_put_i,
  input  logic [7:0]           rx_data_i,

  output logic                 tx_pkt_start_o,
  output logic [3:0]           tx_pid_o,
  output logic                 event_datatog_out_o
);

  typedef enum logic [1:0] {
    StIdle,
    StRcvdOut,
    StRcvdData,
    StRcvdDataEnd
  } state_e;

  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidSetup = 4'b1101;
  localparam logic [3:0] PidAck   = 4'b0010;
  localparam logic [3:0] PidNak   = 4'b1010;
  localparam logic [3:0] PidStall = 4'b1110;
  localparam logic [PktW:0] MaxCount = (PktW+1)'(MaxOutPktSizeByte);

  state_e state_q, state_d;

  logic [3:0]           cur_ep_q;
  logic                 setup_q;
  logic                 newpkt_q;
  logic [PktW:0]        count_q;
  logic                 ovf_q;
  logic                 pid_tog_q;
  logic                 put_q;
  logic [PktW-1:0]      put_addr_q;
  logic [7:0]           data_q;
  logic                 acked_q, rollback_q, tx_start_q, evt_q;
  logic [3:0]           tx_pid_q;
  logic [NumOutEps-1:0] tog_q, tog_d;

  logic ep_in_range, ep_active, tok_valid, tok_out, tok_setup, tok_accept;
  logic put_d, inc, ovf_set, latch_pid, flip;
  logic acked_d, rollback_d, tx_start_d, evt_d;
  logic [3:0] tx_pid_d;

  assign ep_in_range = 32'(rx_endp_i) < NumOutEps;
  assign ep_active   = ep_in_range && out_ep_enabled_i[rx_endp_i];
  assign tok_valid   = rx_pkt_end_i && rx_pkt_valid_i && (rx_pid_i[1:0] == 2'b01) &&
                       (rx_addr_i == dev_addr_i);
  assign tok_out     = tok_valid && (rx_pid_i == PidOut) && ep_active;
  assign tok_setup   = tok_valid && (rx_pid_i == PidSetup) && ep_active &&
                       out_ep_setup_i[rx_endp_i];
  assign tok_accept  = link_active_i && (tok_out || tok_setup) &&
                       ((state_q == StIdle) || (state_q == StRcvdOut));

  assign out_xact_starting_o = tok_accept;
  assign out_xact_start_ep_o = rx_endp_i;

  always_comb begin
    state_d    = state_q;
    put_d      = 1'b0;
    inc        = 1'b0;
    ovf_set    = 1'b0;
    latch_pid  = 1'b0;
    flip       = 1'b0;
    acked_d    = 1'b0;
    rollback_d = 1'b0;
    tx_start_d = 1'b0;
    tx_pid_d   = '0;
    evt_d      = 1'b0;
    if (!link_active_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (tok_accept) state_d = StRcvdOut;
        end
        StRcvdOut: begin
          if (tok_accept)          state_d = StRcvdOut;
          else if (rx_pkt_end_i)   state_d = StIdle;
          else if (rx_pkt_start_i) state_d = StRcvdData;
        end
        StRcvdData: begin
          if (rx_data_put_i) begin
            if (count_q < MaxCount) begin
              put_d = 1'b1;
              inc   = 1'b1;
            end else begin
              ovf_set = 1'b1;
            end
          end
          if (rx_pkt_end_i) begin
            if (rx_pkt_valid_i && (rx_pid_i[1:0] == 2'b11)) begin
              state_d   = StRcvdDataEnd;
              latch_pid = 1'b1;
            end else begin
              state_d    = StIdle;
              rollback_d = 1'b1;
            end
          end
        end
        StRcvdDataEnd: begin
          state_d = StIdle;
          // Isochronous first: no handshake at all, only commit or discard.
          if (out_ep_iso_i[cur_ep_q]) begin
            if (ovf_q) rollback_d = 1'b1;
            else       acked_d    = 1'b1;
          end else if (out_ep_stall_i[cur_ep_q] && !setup_q) begin
            tx_start_d = 1'b1;
            tx_pid_d   = PidStall;
          end else if (out_ep_full_i[cur_ep_q] || ovf_q) begin
            tx_start_d = 1'b1;
            tx_pid_d   = PidNak;
            rollback_d = 1'b1;
          end else if (pid_tog_q != tog_q[cur_ep_q]) begin
            tx_start_d = 1'b1;
            tx_pid_d   = PidAck;
            rollback_d = 1'b1;
            evt_d      = 1'b1;
          end else begin
            tx_start_d = 1'b1;
            tx_pid_d   = PidAck;
            acked_d    = 1'b1;
            flip       = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Engine updates land first; a simultaneous software write overrides masked bits.
  always_comb begin
    tog_d = tog_q;
    if (tok_accept && tok_setup) tog_d[rx_endp_i] = 1'b0;
    if (flip) tog_d[cur_ep_q] = ~tog_q[cur_ep_q];
    if (out_datatog_we_i) tog_d = (tog_d & ~out_datatog_mask_i) |
                                  (out_datatog_status_i & out_datatog_mask_i);
  end

  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cur_ep_q   <= '0;
      setup_q    <= 1'b0;
      newpkt_q   <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      pid_tog_q  <= 1'b0;
      put_q      <= 1'b0;
      put_addr_q <= '0;
      data_q     <= '0;
      acked_q    <= 1'b0;
      rollback_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_pid_q   <= '0;
      evt_q      <= 1'b0;
      tog_q      <= '0;
    end else if (link_reset_i) begin
      state_q    <= StIdle;
      cur_ep_q   <= '0;
      setup_q    <= 1'b0;
      newpkt_q   <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      pid_tog_q  <= 1'b0;
      put_q      <= 1'b0;
      put_addr_q <= '0;
      data_q     <= '0;
      acked_q    <= 1'b0;
      rollback_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_pid_q   <= '0;
      evt_q      <= 1'b0;
      tog_q      <= '0;
    end else begin
      state_q  <= state_d;
      newpkt_q <= tok_accept;
      if (tok_accept) begin
        cur_ep_q <= rx_endp_i;
        setup_q  <= tok_setup;
        count_q  <= '0;
        ovf_q    <= 1'b0;
      end else begin
        if (inc)     count_q <= count_q + 1'b1;
        if (ovf_set) ovf_q   <= 1'b1;
      end
      if (latch_pid) pid_tog_q <= rx_pid_i[3];
      put_q <= put_d;
      if (put_d) begin
        put_addr_q <= count_q[PktW-1:0];
        data_q     <= rx_data_i;
      end
      acked_q    <= acked_d;
      rollback_q <= rollback_d;
      tx_start_q <= tx_start_d;
      tx_pid_q   <= tx_pid_d;
      evt_q      <= evt_d;
      tog_q      <= tog_d;
    end
  end

  assign out_ep_current_o    = cur_ep_q;
  assign out_ep_setup_o      = setup_q;
  assign out_ep_newpkt_o     = newpkt_q;
  assign out_ep_data_put_o   = put_q;
  assign out_ep_put_addr_o   = put_addr_q;
  assign out_ep_data_o       = data_q;
  assign out_ep_acked_o      = acked_q;
  assign out_ep_rollback_o   = rollback_q;
  assign out_data_toggle_o   = tog_q;
  assign tx_pkt_start_o      = tx_start_q;
  assign tx_pid_o            = tx_pid_q;
  assign event_datatog_out_o = evt_q;

endmodule

// File: tb/tb_usb_fs_nb_out_pe.sv
// Directed bench for usb_fs_nb_out_pe: a table of OUT/SETUP transactions with
// hand-computed outcomes, then toggle write, link-inactive and link-reset sequences.
module tb_usb_fs_nb_out_pe;
  localparam int NumOutEps = 12;
  localparam int MaxBytes  = 32;
  localparam int PktW      = 5;

  localparam logic [3:0] POUT = 4'b0001, PSETUP = 4'b1101, PD0 = 4'b0011, PD1 = 4'b1011;
  localparam logic [3:0] PACK = 4'b0010, PNAK = 4'b1010, PSTALL = 4'b1110;
  localparam logic [6:0] DEV = 7'h2A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic link_reset = 1'b0, link_active = 1'b1;
  logic xstart, setup_o, newpkt, put, acked, rollback, tx_start, evt;
  logic [3:0] xstart_ep, cur_ep, tx_pid;
  logic [PktW-1:0] put_addr;
  logic [7:0] put_data;
  logic [NumOutEps-1:0] enabled = 12'h00F, setup_cap = 12'h001, full = '0;
  logic [NumOutEps-1:0] stall = 12'h001, iso = 12'h008, toggles;
  logic tog_we = 1'b0;
  logic [NumOutEps-1:0] tog_status = '0, tog_mask = '0;
  logic rx_start = 1'b0, rx_end = 1'b0, rx_valid = 1'b0, rx_put = 1'b0;
  logic [3:0] rx_pid = '0, rx_endp = '0;
  logic [6:0] rx_addr = '0;
  logic [7:0] rx_data = '0;

  usb_fs_nb_out_pe #(.NumOutEps(NumOutEps), .MaxOutPktSizeByte(MaxBytes)) dut (
    .clk_48mhz_i(clk), .rst_ni(rst_n), .link_reset_i(link_reset), .link_active_i(link_active),
    .dev_addr_i(DEV), .out_xact_starting_o(xstart), .out_xact_start_ep_o(xstart_ep),
    .out_ep_current_o(cur_ep), .out_ep_setup_o(setup_o), .out_ep_newpkt_o(newpkt),
    .out_ep_data_put_o(put), .out_ep_put_addr_o(put_addr), .out_ep_data_o(put_data),
    .out_ep_acked_o(acked), .out_ep_rollback_o(rollback), .out_ep_enabled_i(enabled),
    .out_ep_setup_i(setup_cap), .out_ep_full_i(full), .out_ep_stall_i(stall),
    .out_ep_iso_i(iso), .out_data_toggle_o(toggles), .out_datatog_we_i(tog_we),
    .out_datatog_status_i(tog_status), .out_datatog_mask_i(tog_mask),
    .rx_pkt_start_i(rx_start), .rx_pkt_end_i(rx_end), .rx_pkt_valid_i(rx_valid),
    .rx_pid_i(rx_pid), .rx_addr_i(rx_addr), .rx_endp_i(rx_endp), .rx_data_put_i(rx_put),
    .rx_data_i(rx_data), .tx_pkt_start_o(tx_start), .tx_pid_o(tx_pid),
    .event_datatog_out_o(evt)
  );

  // Cumulative pulse counters, sampled on the falling edge.
  int put_cnt = 0, ack_cnt = 0, rb_cnt = 0, tx_cnt = 0, evt_cnt = 0, new_cnt = 0, pid_idle_err = 0;
  logic [3:0] last_pid = '0;
  logic [PktW-1:0] addr_log [256];
  logic [7:0] data_log [256];

  always @(negedge clk) begin
    if (rst_n) begin
      if (put) begin
        addr_log[put_cnt % 256] = put_addr;
        data_log[put_cnt % 256] = put_data;
        put_cnt++;
      end
      if (acked) ack_cnt++;
      if (rollback) rb_cnt++;
      if (evt) evt_cnt++;
      if (newpkt) new_cnt++;
      if (tx_start) begin
        tx_cnt++;
        last_pid = tx_pid;
      end else if (tx_pid != 4'd0) begin
        pid_idle_err++;
      end
    end
  end

  int n_checks = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] tok; logic [3:0] ep; bit bad_addr; bit full; logic [3:0] dpid; bit dvalid;
    int nbytes; logic [7:0] seed;
    bit exp_start; int exp_puts; int exp_tx; logic [3:0] exp_pid; int exp_ack; int exp_rb;
    int exp_evt; logic [11:0] exp_tog; bit exp_setup; logic [3:0] exp_cur;
  } vec_t;

  vec_t vecs [16];

  task automatic run_xact(input vec_t v, output logic start_seen);
    @(negedge clk);
    rx_end = 1'b1; rx_valid = 1'b1; rx_pid = v.tok; rx_endp = v.ep;
    rx_addr = v.bad_addr ? (DEV ^ 7'h01) : DEV;
    full = v.full ? (12'b1 << v.ep) : '0;
    #1 start_seen = xstart;
    @(negedge clk); rx_end = 1'b0; rx_valid = 1'b0;
    @(negedge clk); rx_start = 1'b1;
    @(negedge clk); rx_start = 1'b0;
    for (int i = 0; i < v.nbytes; i++) begin
      @(negedge clk); rx_put = 1'b1; rx_data = v.seed + 8'(i) * 8'h11;
    end
    @(negedge clk); rx_put = 1'b0; rx_end = 1'b1; rx_valid = v.dvalid; rx_pid = v.dpid;
    @(negedge clk); rx_end = 1'b0; rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s;
    int p0, a0, r0, t0, e0, n0, bad, np;
    //              tok    ep  bad full dpid dv  n  seed   st puts tx pid     ack rb evt tog     su cur
    vecs[0]  = '{POUT,   1, 0, 0, PD0, 1,  4, 8'h11, 1,  4, 1, PACK,   1, 0, 0, 12'h002, 0, 1};
    vecs[1]  = '{POUT,   1, 0, 0, PD0, 1,  4, 8'h11, 1,  4, 1, PACK,   0, 1, 1, 12'h002, 0, 1};
    vecs[2]  = '{PSETUP, 0, 0, 0, PD0, 1,  8, 8'h01, 1,  8, 1, PACK,   1, 0, 0, 12'h003, 1, 0};
    vecs[3]  = '{POUT,   2, 0, 1, PD0, 1,  3, 8'h05, 1,  3, 1, PNAK,   0, 1, 0, 12'h003, 0, 2};
    vecs[4]  = '{POUT,   2, 0, 0, PD0, 1, 33, 8'h07, 1, 32, 1, PNAK,   0, 1, 0, 12'h003, 0, 2};
    vecs[5]  = '{POUT,   3, 0, 0, PD0, 1,  2, 8'h09, 1,  2, 0, 4'h0,   1, 0, 0, 12'h003, 0, 3};
    vecs[6]  = '{POUT,   0, 0, 0, PD1, 1,  1, 8'h0A, 1,  1, 1, PSTALL, 0, 0, 0, 12'h003, 0, 0};
    vecs[7]  = '{POUT,   2, 0, 0, PD0, 1, 32, 8'h0B, 1, 32, 1, PACK,   1, 0, 0, 12'h007, 0, 2};
    vecs[8]  = '{POUT,   2, 0, 0, PD1, 1,  1, 8'h0C, 1,  1, 1, PACK,   1, 0, 0, 12'h003, 0, 2};
    vecs[9]  = '{POUT,   2, 0, 0, PD0, 0,  2, 8'h0D, 1,  2, 0, 4'h0,   0, 1, 0, 12'h003, 0, 2};
    vecs[10] = '{POUT,  13, 0, 0, PD0, 1,  3, 8'h0E, 0,  0, 0, 4'h0,   0, 0, 0, 12'h003, 0, 2};
    vecs[11] = '{POUT,   4, 0, 0, PD0, 1,  3, 8'h0F, 0,  0, 0, 4'h0,   0, 0, 0, 12'h003, 0, 2};
    vecs[12] = '{PSETUP, 1, 0, 0, PD0, 1,  3, 8'h10, 0,  0, 0, 4'h0,   0, 0, 0, 12'h003, 0, 2};
    vecs[13] = '{POUT,   1, 1, 0, PD0, 1,  3, 8'h12, 0,  0, 0, 4'h0,   0, 0, 0, 12'h003, 0, 2};
    vecs[14] = '{POUT,   3, 0, 0, PD0, 1, 33, 8'h13, 1, 32, 0, 4'h0,   0, 1, 0, 12'h003, 0, 3};
    vecs[15] = '{POUT,   1, 0, 0, PD1, 1,  2, 8'h14, 1,  2, 1, PACK,   1, 0, 0, 12'h001, 0, 1};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("reset_toggles", toggles, 0);
    check("reset_tx", {tx_start, tx_pid}, 0);
    check("reset_cur_setup", {cur_ep, setup_o}, 0);
    check("reset_strobes", {put, acked, rollback, newpkt, evt}, 0);

    for (int r = 0; r < 16; r++) begin
      p0 = put_cnt; a0 = ack_cnt; r0 = rb_cnt; t0 = tx_cnt; e0 = evt_cnt; n0 = new_cnt;
      run_xact(vecs[r], s);
      np = put_cnt - p0;
      check($sformatf("v%0d_xstart", r), 32'(s), 32'(vecs[r].exp_start));
      check($sformatf("v%0d_newpkt", r), new_cnt - n0, 32'(vecs[r].exp_start));
      check($sformatf("v%0d_puts", r), np, vecs[r].exp_puts);
      check($sformatf("v%0d_tx", r), tx_cnt - t0, vecs[r].exp_tx);
      if (vecs[r].exp_tx != 0) check($sformatf("v%0d_pid", r), last_pid, vecs[r].exp_pid);
      check($sformatf("v%0d_acked", r), ack_cnt - a0, vecs[r].exp_ack);
      check($sformatf("v%0d_rollback", r), rb_cnt - r0, vecs[r].exp_rb);
      check($sformatf("v%0d_evt", r), evt_cnt - e0, vecs[r].exp_evt);
      check($sformatf("v%0d_toggles", r), toggles, vecs[r].exp_tog);
      check($sformatf("v%0d_setup", r), setup_o, vecs[r].exp_setup);
      check($sformatf("v%0d_cur", r), cur_ep, vecs[r].exp_cur);
      bad = 0;
      for (int k = 0; k < np && k < 64; k++) begin
        if (addr_log[(p0 + k) % 256] != PktW'(k) ||
            data_log[(p0 + k) % 256] != vecs[r].seed + 8'(k) * 8'h11) bad++;
      end
      check($sformatf("v%0d_put_content", r), bad, 0);
    end

    // Software toggle write: (0x001 & ~0x006) | (0x00C & 0x006) = 0x005
    @(negedge clk); tog_we = 1'b1; tog_status = 12'h00C; tog_mask = 12'h006;
    @(negedge clk); tog_we = 1'b0; #1;
    check("sw_toggle_write", toggles, 12'h005);

    // Link goes inactive mid-packet: puts already made stand, nothing else follows.
    p0 = put_cnt; a0 = ack_cnt; r0 = rb_cnt; t0 = tx_cnt;
    @(negedge clk); rx_end = 1'b1; rx_valid = 1'b1; rx_pid = POUT; rx_addr = DEV; rx_endp = 4'd1;
    full = '0;
    @(negedge clk); rx_end = 1'b0; rx_valid = 1'b0;
    @(negedge clk); rx_start = 1'b1;
    @(negedge clk); rx_start = 1'b0; rx_put = 1'b1; rx_data = 8'hA1;
    @(negedge clk); rx_data = 8'hA2;
    @(negedge clk); rx_put = 1'b0; link_active = 1'b0;
    @(negedge clk); link_active = 1'b1;
    @(negedge clk); rx_end = 1'b1; rx_valid = 1'b1; rx_pid = PD0;
    @(negedge clk); rx_end = 1'b0; rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("inactive_puts", put_cnt - p0, 2);
    check("inactive_tx", tx_cnt - t0, 0);
    check("inactive_ack_rb", (ack_cnt - a0) + (rb_cnt - r0), 0);
    check("inactive_toggles", toggles, 12'h005);

    @(negedge clk); link_reset = 1'b1;
    @(negedge clk); link_reset = 1'b0; #1;
    check("link_reset_toggles", toggles, 0);
    check("link_reset_cur", cur_ep, 0);

    check("tx_pid_idle_zero", pid_idle_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
